// File: rtl/vcnpu_tile_scheduler.sv
// vcnpu_tile_scheduler: raster-order frame-to-tile dispatcher, round-robin over idle cores.
// Optional perf counters: define VCNPU_SCHED_PERF_EN.
module vcnpu_tile_scheduler #(
  parameter  int NUM_CORES = 2,
  parameter  int WIDTH     = 16,
  localparam int CW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     frame_H,
  input  logic [WIDTH-1:0]     frame_W,
  input  logic [WIDTH-1:0]     tile_rows,
  input  logic [WIDTH-1:0]     tile_cols_max,
  input  logic                 is_dfconv,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [CW-1:0]        tile_core,
  output logic [WIDTH-1:0]     tile_row0,
  output logic [WIDTH-1:0]     tile_col0,
  output logic [WIDTH-1:0]     tile_h,
  output logic [WIDTH-1:0]     tile_w,
  output logic                 tile_last,
  output logic                 tile_dfconv,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
`ifdef VCNPU_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     h_q, w_q, tr_q, tc_q;
  logic [WIDTH-1:0]     row0_q, col0_q;
  logic                 df_q, err_q;
  logic [NUM_CORES-1:0] outst_q, outst_d;
  logic [CW-1:0]        rr_q, pick;
  logic                 found, geo_bad, accept;
  logic                 row_end, col_end;
  logic [WIDTH:0]       row_sum, col_sum;

  // Cyclic search for the first idle core starting at the rr pointer
  always_comb begin
    int idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_q) + k) % NUM_CORES;
      if (!found && !outst_q[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  assign geo_bad = (h_q == '0) || (w_q == '0) ||
                   (tr_q == '0) || (tc_q == '0);

  assign row_sum = {1'b0, row0_q} + {1'b0, tr_q};
  assign col_sum = {1'b0, col0_q} + {1'b0, tc_q};
  assign row_end = row_sum >= {1'b0, h_q};
  assign col_end = col_sum >= {1'b0, w_q};

  assign tile_valid  = (state_q == ISSUE) && !geo_bad && found;
  assign accept      = tile_valid && tile_ready;
  assign tile_core   = pick;
  assign tile_row0   = row0_q;
  assign tile_col0   = col0_q;
  assign tile_h      = (row_sum > {1'b0, h_q}) ? (h_q - row0_q) : tr_q;
  assign tile_w      = (col_sum > {1'b0, w_q}) ? (w_q - col0_q) : tc_q;
  assign tile_last   = tile_valid && row_end && col_end;
  assign tile_dfconv = df_q;
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign cfg_err     = err_q;

  always_comb begin
    outst_d = outst_q & ~core_done;
    if (accept) outst_d[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: begin
        if (geo_bad)                 state_d = DONE;
        else if (accept && tile_last) state_d = DRAIN;
      end
      DRAIN: if (outst_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      w_q     <= '0;
      tr_q    <= '0;
      tc_q    <= '0;
      df_q    <= 1'b0;
      err_q   <= 1'b0;
      row0_q  <= '0;
      col0_q  <= '0;
      outst_q <= '0;
      rr_q    <= '0;
    end else begin
      outst_q <= outst_d;
      if (state_q == IDLE && start) begin
        h_q    <= frame_H;
        w_q    <= frame_W;
        tr_q   <= tile_rows;
        tc_q   <= tile_cols_max;
        df_q   <= is_dfconv;
        err_q  <= 1'b0;
        row0_q <= '0;
        col0_q <= '0;
      end
      // Zero geometry is judged on the latched copy, one cycle after start
      if (state_q == ISSUE && geo_bad) err_q <= 1'b1;
      if (accept) begin
        rr_q <= (pick == CW'(NUM_CORES - 1)) ? '0 : pick + 1'b1;
        if (col_end) begin
          col0_q <= '0;
          row0_q <= row_sum[WIDTH-1:0];
        end else begin
          col0_q <= col_sum[WIDTH-1:0];
        end
      end
    end
  end

`ifdef VCNPU_SCHED_PERF_EN
  logic stall;
  assign stall = (state_q == ISSUE) &&
                 (!found || (tile_valid && !tile_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
      if (stall && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vcnpu_tile_scheduler.sv
// tb_vcnpu_tile_scheduler: directed checks of tile order, clipping, handshake, drain and reset.
// Core completions come from a per-core countdown started on each accepted tile.
module tb_vcnpu_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] frame_H = '0, frame_W = '0;
  logic [15:0] tile_rows = '0, tile_cols_max = '0;
  logic        is_dfconv = 1'b0;
  logic [1:0]  core_done = '0;
  logic        tile_valid, tile_ready = 1'b1;
  logic [0:0]  tile_core;
  logic [15:0] tile_row0, tile_col0, tile_h, tile_w;
  logic        tile_last, tile_dfconv, busy, done, cfg_err;
`ifdef VCNPU_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  vcnpu_tile_scheduler #(.NUM_CORES(2), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .frame_H(frame_H), .frame_W(frame_W),
    .tile_rows(tile_rows), .tile_cols_max(tile_cols_max),
    .is_dfconv(is_dfconv), .core_done(core_done),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_core(tile_core), .tile_row0(tile_row0),
    .tile_col0(tile_col0), .tile_h(tile_h), .tile_w(tile_w),
    .tile_last(tile_last), .tile_dfconv(tile_dfconv),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef VCNPU_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r, c, h, w;
    logic [0:0]  core;
    logic        last, df;
  } tile_t;

  tile_t log_q[$];
  int    n_run = 0, n_fail = 0;
  int    ndone = 0;
  logic  busy_at_done = 1'b0;
  logic  saw_valid = 1'b0;
  int    cnt[2] = '{0, 0};
  logic [1:0] pend = '0, man = '0, auto_en = 2'b11;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive completions, sample at negedge, advance the core model
  task automatic cyc();
    logic       acc;
    logic [0:0] acc_core;
    tile_t      e;
    core_done = pend | man;
    man = '0;
    #1;
    acc = tile_valid && tile_ready;
    acc_core = tile_core;
    if (tile_valid) saw_valid = 1'b1;
    if (done) begin
      ndone++;
      busy_at_done = busy;
    end
    if (acc) begin
      e.r = tile_row0; e.c = tile_col0;
      e.h = tile_h; e.w = tile_w;
      e.core = tile_core; e.last = tile_last; e.df = tile_dfconv;
      log_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pend = '0;
    for (int i = 0; i < 2; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0 && auto_en[i]) pend[i] = 1'b1;
      end
    end
    if (acc) cnt[acc_core] = 2;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [15:0] h, w, tr, tc,
                             input logic df);
    log_q.delete();
    ndone = 0;
    saw_valid = 1'b0;
    frame_H = h; frame_W = w;
    tile_rows = tr; tile_cols_max = tc;
    is_dfconv = df;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int budget);
    int n = 0;
    int post = 0;
    while (n < budget && post < 3) begin
      cyc();
      n++;
      if (ndone > 0) post++;
    end
    chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_geom"}, {tile_row0, tile_col0, tile_h, tile_w}, 64'd0);
    chk({tag, "_flags"}, {tile_valid, tile_core, tile_last, tile_dfconv,
                          busy, done, cfg_err}, 64'd0);
  endtask

  initial begin
    int er[6], ec[6], eh[6], ew[6];
    int n00;
    logic [63:0] snap;

    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8x8 frame, 4x4 tiles
    start_frame(16'd8, 16'd8, 16'd4, 16'd4, 1'b1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_valid", 64'(tile_valid), 64'd1);
    run_frame("t1", 60);
    er = '{0, 0, 4, 4, 0, 0};
    ec = '{0, 4, 0, 4, 0, 0};
    chk("t1_count", 64'(log_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      chk($sformatf("t1_pos%0d", i), {log_q[i].r, log_q[i].c},
          {16'(er[i]), 16'(ec[i])});
      chk($sformatf("t1_size%0d", i), {log_q[i].h, log_q[i].w},
          {16'd4, 16'd4});
      chk($sformatf("t1_core%0d", i), 64'(log_q[i].core), 64'(i % 2));
      chk($sformatf("t1_last%0d", i), 64'(log_q[i].last), 64'(i == 3));
      chk($sformatf("t1_df%0d", i), 64'(log_q[i].df), 64'd1);
    end
    chk("t1_done", 64'(ndone), 64'd1);
    chk("t1_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("t1_cfg_err", 64'(cfg_err), 64'd0);

    // 10x6 frame with clipped edge tiles
    start_frame(16'd10, 16'd6, 16'd4, 16'd4, 1'b0);
    run_frame("t2", 80);
    er = '{0, 0, 4, 4, 8, 8};
    ec = '{0, 4, 0, 4, 0, 4};
    eh = '{4, 4, 4, 4, 2, 2};
    ew = '{4, 2, 4, 2, 4, 2};
    chk("t2_count", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk($sformatf("t2_tile%0d", i),
          {log_q[i].r, log_q[i].c, log_q[i].h, log_q[i].w},
          {16'(er[i]), 16'(ec[i]), 16'(eh[i]), 16'(ew[i])});
      chk($sformatf("t2_last%0d", i), 64'(log_q[i].last), 64'(i == 5));
    end
    chk("t2_done", 64'(ndone), 64'd1);

    // Zero frame height
    start_frame(16'd0, 16'd8, 16'd4, 16'd4, 1'b0);
    chk("t3_done_n1", 64'(done), 64'd0);
    cyc();
    chk("t3_done_n2", 64'(done), 64'd1);
    chk("t3_err_n2", 64'(cfg_err), 64'd1);
    cyc();
    cyc();
    chk("t3_done_once", 64'(ndone), 64'd1);
    chk("t3_err_sticky", 64'(cfg_err), 64'd1);
    chk("t3_no_valid", 64'(saw_valid), 64'd0);

    // Backpressure on the first tile
    tile_ready = 1'b0;
    start_frame(16'd8, 16'd8, 16'd4, 16'd4, 1'b0);
    chk("t4_err_clear", 64'(cfg_err), 64'd0);
    snap = {tile_row0, tile_col0, tile_h, tile_w};
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t4_valid%0d", i), 64'(tile_valid), 64'd1);
      chk($sformatf("t4_hold%0d", i),
          {tile_row0, tile_col0, tile_h, tile_w}, snap);
    end
    chk("t4_snap", snap, {16'd0, 16'd0, 16'd4, 16'd4});
    tile_ready = 1'b1;
    run_frame("t4", 60);
    n00 = 0;
    foreach (log_q[i]) if (log_q[i].r == 0 && log_q[i].c == 0) n00++;
    chk("t4_count", 64'(log_q.size()), 64'd4);
    chk("t4_once", 64'(n00), 64'd1);

    // Core 1 never completes; core 0 completed by hand
    auto_en = 2'b00;
    start_frame(16'd8, 16'd8, 16'd4, 16'd4, 1'b0);
    cyc();
    cyc();
    chk("t5_stall", 64'(tile_valid), 64'd0);
    cyc();
    cyc();
    cyc();
    chk("t5_still", {tile_valid, busy}, 64'b01);
    man = 2'b01;
    cyc();
    chk("t5_reissue", {tile_valid, tile_core, busy}, 64'b101);
    chk("t5_pos", {tile_row0, tile_col0}, {16'd4, 16'd0});

    // Asynchronous reset mid-frame
    ndone = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    cnt = '{0, 0};
    pend = '0;
    cyc();
    cyc();
    chk("t6_no_done", 64'(ndone), 64'd0);
    chk_zero("t6_held");
    rst_n = 1'b1;
    auto_en = 2'b11;
    start_frame(16'd8, 16'd8, 16'd4, 16'd4, 1'b0);
    run_frame("t6", 60);
    chk("t6_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() > 0)
      chk("t6_first", {log_q[0].r, log_q[0].c, 15'd0, log_q[0].core},
          64'd0);
    chk("t6_done", 64'(ndone), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
